// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver (start bit, FRAME_BITS data LSB first, one stop bit).
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the bit midpoint.
module uart_rx #(
  parameter int FRAME_BITS = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  rx_status
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(FRAME_BITS);
  localparam logic [SCW-1:0] LAST_CNT = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SCW-1:0] VOTE0_CNT  = SCW'(OVERSAMPLE / 2 - 2);
  localparam logic [SCW-1:0] VOTE1_CNT  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] DECIDE_CNT = SCW'(OVERSAMPLE / 2);
`else
  localparam logic [SCW-1:0] DECIDE_CNT = SCW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    BREAK = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q;
  logic                  rx_s;
  logic [SCW-1:0]        sample_cnt_q, sample_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_status_q, rx_status_d;
  logic [SCW-1:0]        cnt_next_s;
  logic                  decide_s;
  logic                  bit_val_s;

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s    <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two early vote samples; the third is the live sample at the decision tick.
  always_comb begin
    vote_d = vote_q;
    if (baud_tick && (sample_cnt_q == VOTE0_CNT)) begin
      vote_d[0] = rx_s;
    end else begin
      vote_d[0] = vote_q[0];
    end
    if (baud_tick && (sample_cnt_q == VOTE1_CNT)) begin
      vote_d[1] = rx_s;
    end else begin
      vote_d[1] = vote_q[1];
    end
  end

  // Vote sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_q <= 2'b11;
    end else begin
      vote_q <= vote_d;
    end
  end

  assign bit_val_s = maj3(vote_q[0], vote_q[1], rx_s);
`else
  assign bit_val_s = rx_s;
`endif

  assign cnt_next_s = (sample_cnt_q == LAST_CNT) ? {SCW{1'b0}} : (sample_cnt_q + SCW'(1));
  assign decide_s   = baud_tick && (sample_cnt_q == DECIDE_CNT);

  // Next-state, counter, shift register and output-strobe logic.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;

    if (baud_tick && (state_q inside {START, DATA, STOP})) begin
      sample_cnt_d = cnt_next_s;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end

    case (state_q)
      IDLE: begin
        // The detecting tick counts as sample 0 of the start bit.
        if (baud_tick && !rx_s) begin
          state_d      = START;
          sample_cnt_d = SCW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (decide_s) begin
          if (!bit_val_s) begin
            state_d = DATA;
          end else begin
            state_d      = IDLE;
            sample_cnt_d = {SCW{1'b0}};
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (decide_s) begin
          shift_d = {bit_val_s, shift_q[FRAME_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = {BCW{1'b0}};
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            state_d   = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (decide_s) begin
          sample_cnt_d = {SCW{1'b0}};
          if (bit_val_s) begin
            state_d    = DONE;
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      BREAK: begin
        if (baud_tick && rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d      = IDLE;
        sample_cnt_d = {SCW{1'b0}};
        bit_cnt_d    = {BCW{1'b0}};
      end
    endcase

    rx_status_d = (state_d inside {START, DATA, STOP, BREAK});
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= {SCW{1'b0}};
      bit_cnt_q    <= {BCW{1'b0}};
      shift_q      <= {FRAME_BITS{1'b0}};
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
    end
  end

  // Registered outputs; strobes are high for the single clk spent in DONE or entering BREAK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q   <= {FRAME_BITS{1'b0}};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_status_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_status_q <= rx_status_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_status = rx_status_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter FRAME_BITS, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period; an even value of at least 4.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 baud_tick  input  1  one-clk strobe at OVERSAMPLE times the baud rate.
REQ-006 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-007 rx_data  output  FRAME_BITS  last correctly framed word, LSB received first.
REQ-008 rx_valid  output  1  one-clk pulse; rx_data updated on the same edge.
REQ-009 frame_err  output  1  one-clk pulse on a bad stop bit.
REQ-010 rx_status  output  1  high while a frame is in progress, low when idle (same sense as the transmitter's tx_status).

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (rx_s).
REQ-012 States SHALL be IDLE, START, DATA, STOP, DONE, BREAK.
REQ-013 bit_cnt SHALL be $clog2(FRAME_BITS) bits wide; sample_cnt SHALL be $clog2(OVERSAMPLE) bits wide; both advance only on baud_tick.
REQ-014 IDLE: on baud_tick with rx_s=0, the block SHALL go to START with sample_cnt=1; without baud_tick it SHALL hold.
REQ-015 START: the midpoint sample SHALL be taken at the baud_tick where sample_cnt=OVERSAMPLE/2-1; value 0 -> DATA; value 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 sample_cnt SHALL wrap OVERSAMPLE-1 -> 0, giving exactly OVERSAMPLE ticks per bit period.
REQ-017 DATA: on each midpoint tick the sampled bit SHALL be shifted in LSB-first; after bit FRAME_BITS-1 -> STOP, bit_cnt SHALL reset to 0.
REQ-018 STOP: midpoint sample 1 -> DONE; 0 -> frame_err pulse, then BREAK.
REQ-019 DONE: for one clk, rx_data SHALL load the shift register and rx_valid SHALL pulse; then -> IDLE.
REQ-020 BREAK: the block SHALL hold until rx_s=1 on a baud_tick, then go to IDLE; a held-low line yields exactly one frame_err.
REQ-021 rx_data SHALL be unchanged on a framing error or glitch rejection.
REQ-022 rx_status SHALL be 1 in START, DATA, STOP and BREAK, and 0 in IDLE and DONE.
REQ-023 rx_valid and frame_err SHALL never be asserted on the same clk.

Reset
REQ-024 Assertion SHALL be immediate and independent of clk: state=IDLE, rx_data=0, rx_valid=0, frame_err=0, rx_status=0, counters=0, synchronizer=1.
REQ-025 Reset mid-frame SHALL discard the partial word with no rx_valid or frame_err pulse; after release, reception SHALL restart on the next start edge.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN.
REQ-027 Defined: each bit value SHALL be the 2-of-3 majority of rx_s at sample_cnt OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2, decided at the OVERSAMPLE/2 tick; every bit decision moves one baud_tick later; applies to start, data and stop.
REQ-028 Undefined: bit value SHALL be the single rx_s sample at sample_cnt=OVERSAMPLE/2-1; no vote logic is instantiated.

Verification (FRAME_BITS=8, OVERSAMPLE=16, baud_tick every 4 clk)
REQ-029 Frame 0xA5 with a good stop bit -> exactly one rx_valid, rx_data=0xA5, frame_err=0, rx_status low after DONE.
REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, with values 0x00 then 0xFF.
REQ-031 Low glitch of 3 baud_ticks on an idle line -> return to IDLE, no rx_valid, no frame_err, rx_data unchanged.
REQ-032 Frame 0x3C with the stop bit driven 0 and the line then released -> one frame_err, no rx_valid, rx_data unchanged; next frame 0x5A is received correctly.
REQ-033 Line held low for 40 bit periods -> exactly one frame_err; reception resumes after the line goes high.
REQ-034 Reset asserted mid-DATA, then frame 0x81 -> no pulse from the aborted frame, rx_data=0x81; with UART_RX_MAJORITY_EN, one-tick spikes at each midpoint of 0x81 -> still 0x81.
